// File: rtl/long_wb_pkg.sv
// long_wb_pkg: writeback entry type and round-robin pick helper for long_wb_arb
`include "defines.svh"
package long_wb_pkg;
  localparam int REG_AW  = `REG_ADDR_WIDTH;
  localparam int CID_W   = `COMMIT_ID_WIDTH;
  localparam int MAX_SRC = 8;
  typedef struct packed {
    logic [CID_W-1:0]  commit_id;
    logic [REG_AW-1:0] rd_addr;
    logic              rd_we;
    logic [31:0]       rd_data;
  } wb_entry_t;
  function automatic logic [MAX_SRC-1:0] rr_pick(input logic [MAX_SRC-1:0] req, input logic [2:0] ptr, input int n);
    logic [MAX_SRC-1:0] gnt;
    logic found;
    int idx;
    gnt = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_SRC; k++) begin
      if (k < n) begin
        idx = int'(ptr) + k;
        if (idx >= n) idx = idx - n;
        if (!found && req[idx[2:0]]) begin
          gnt[idx[2:0]] = 1'b1;
          found = 1'b1;
        end
      end
    end
    return gnt;
  endfunction
endpackage

// File: rtl/defines.svh
// defines.svh: global widths shared by the long-latency writeback path
`ifndef LONG_WB_DEFINES_SVH
`define LONG_WB_DEFINES_SVH
`define REG_ADDR_WIDTH 5
`define COMMIT_ID_WIDTH 4
`endif

// File: rtl/long_wb_fifo.sv
// long_wb_fifo: single-clock FIFO of writeback entries with registered full/empty flags
module long_wb_fifo
  import long_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_i,
  input  logic      pop_i,
  input  wb_entry_t din_i,
  output wb_entry_t dout_o,
  output logic      full_o,
  output logic      empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  wb_entry_t mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] cnt_q, cnt_d;
  logic full_q, empty_q;
  // occupancy after this cycle's push/pop
  always_comb cnt_d = cnt_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
  // storage needs no reset: entries are only read while the FIFO is non-empty
  always_ff @(posedge clk)
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  // pointers and flags; full comes out of reset set so nothing is accepted until the first clock
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b1;
      empty_q  <= 1'b1;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q   <= cnt_d;
      full_q  <= cnt_d == FULL_CNT;
      empty_q <= cnt_d == '0;
    end
  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
endmodule

// File: rtl/long_wb_arb.sv
// long_wb_arb: round-robin writeback arbiter for long-latency units; define LONG_WB_BYPASS_EN to let an empty-FIFO source skip its buffer
`include "defines.svh"
module long_wb_arb
  import long_wb_pkg::*;
#(
  parameter int NUM_SRC    = 3,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_SRC-1:0]                  src_valid_i,
  output logic [NUM_SRC-1:0]                  src_ready_o,
  input  logic [NUM_SRC*`COMMIT_ID_WIDTH-1:0] src_commit_id_i,
  input  logic [NUM_SRC*`REG_ADDR_WIDTH-1:0]  src_rd_addr_i,
  input  logic [NUM_SRC-1:0]                  src_rd_we_i,
  input  logic [NUM_SRC*32-1:0]               src_rd_data_i,
  output logic                                reg_we_o,
  output logic [`REG_ADDR_WIDTH-1:0]          reg_waddr_o,
  output logic [31:0]                         reg_wdata_o,
  output logic                                commit_valid_o,
  output logic [`COMMIT_ID_WIDTH-1:0]         commit_id_o
);
  wb_entry_t in_e [NUM_SRC];
  wb_entry_t head [NUM_SRC];
  wb_entry_t win;
  logic [NUM_SRC-1:0] full, empty, push, pop, req, byp, gnt;
  logic any_gnt;
  logic [2:0] g_idx, rr_ptr_q, rr_ptr_d;
  logic commit_valid_q, reg_we_q;
  logic [CID_W-1:0] commit_id_q;
  logic [REG_AW-1:0] reg_waddr_q;
  logic [31:0] reg_wdata_q;
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign in_e[i] = '{commit_id: src_commit_id_i[i*CID_W +: CID_W],
                       rd_addr:   src_rd_addr_i[i*REG_AW +: REG_AW],
                       rd_we:     src_rd_we_i[i],
                       rd_data:   src_rd_data_i[i*32 +: 32]};
    long_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push[i]),
      .pop_i   (pop[i]),
      .din_i   (in_e[i]),
      .dout_o  (head[i]),
      .full_o  (full[i]),
      .empty_o (empty[i])
    );
  end
  // requests, round-robin grant, FIFO steering and winning payload
  always_comb begin
`ifdef LONG_WB_BYPASS_EN
    byp = empty & ~full & src_valid_i;
`else
    byp = '0;
`endif
    req = ~empty | byp;
    gnt = NUM_SRC'(rr_pick(MAX_SRC'(req), rr_ptr_q, NUM_SRC));
    pop = gnt & ~empty;
    push = src_valid_i & ~full & ~(gnt & empty);
    any_gnt = |gnt;
    g_idx = '0;
    win = '0;
    for (int k = 0; k < NUM_SRC; k++)
      if (gnt[k]) begin
        g_idx = 3'(k);
        win = empty[k] ? in_e[k] : head[k];
      end
    rr_ptr_d = !any_gnt ? rr_ptr_q : (int'(g_idx) == NUM_SRC - 1) ? 3'd0 : g_idx + 3'd1;
  end
  // round-robin pointer and registered writeback/commit outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rr_ptr_q       <= '0;
      commit_valid_q <= 1'b0;
      reg_we_q       <= 1'b0;
      commit_id_q    <= '0;
      reg_waddr_q    <= '0;
      reg_wdata_q    <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      commit_valid_q <= any_gnt;
      reg_we_q       <= any_gnt && win.rd_we && (win.rd_addr != '0);
      if (any_gnt) begin
        commit_id_q <= win.commit_id;
        reg_waddr_q <= win.rd_addr;
        reg_wdata_q <= win.rd_data;
      end
    end
  assign src_ready_o    = ~full;
  assign commit_valid_o = commit_valid_q;
  assign reg_we_o       = reg_we_q;
  assign commit_id_o    = commit_id_q;
  assign reg_waddr_o    = reg_waddr_q;
  assign reg_wdata_o    = reg_wdata_q;
endmodule

// File: tb/tb_long_wb_arb.sv
// tb_long_wb_arb: vector table, corner sequences and random traffic checked against a queue-based reference model
module tb_long_wb_arb;
  import long_wb_pkg::*;
  localparam int N = 3;
  localparam int D = 2;
  localparam int EW = $bits(wb_entry_t);
`ifdef LONG_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [N-1:0] v = '0;
  wb_entry_t in_e [N];
  logic [N-1:0] src_ready, rd_we_f;
  logic [N*CID_W-1:0] cid_f;
  logic [N*REG_AW-1:0] rda_f;
  logic [N*32-1:0] data_f;
  logic reg_we, commit_valid;
  logic [REG_AW-1:0] waddr;
  logic [31:0] wdata;
  logic [CID_W-1:0] cid;
  int checks = 0;
  int failures = 0;
  wb_entry_t mq [N][$];
  int m_ptr;
  logic [N-1:0] m_rdy;
  logic e_cv, e_we;
  logic [CID_W-1:0] e_id;
  logic [REG_AW-1:0] e_wa;
  logic [31:0] e_wd;
  typedef struct {
    logic [N-1:0] v;
    logic [CID_W-1:0] id;
    logic [REG_AW-1:0] rd;
    logic we;
    logic [31:0] data;
    logic cv, rwe;
    logic [CID_W-1:0] eid;
    logic [REG_AW-1:0] ewa;
    logic [31:0] ewd;
    logic [N-1:0] rdy;
  } vec_t;
  vec_t tbl [8];

  always #5 clk = ~clk;

  always_comb
    for (int k = 0; k < N; k++) begin
      cid_f[k*CID_W +: CID_W] = in_e[k].commit_id;
      rda_f[k*REG_AW +: REG_AW] = in_e[k].rd_addr;
      rd_we_f[k] = in_e[k].rd_we;
      data_f[k*32 +: 32] = in_e[k].rd_data;
    end

  long_wb_arb #(.NUM_SRC(N), .FIFO_DEPTH(D)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .src_valid_i     (v),
    .src_ready_o     (src_ready),
    .src_commit_id_i (cid_f),
    .src_rd_addr_i   (rda_f),
    .src_rd_we_i     (rd_we_f),
    .src_rd_data_i   (data_f),
    .reg_we_o        (reg_we),
    .reg_waddr_o     (waddr),
    .reg_wdata_o     (wdata),
    .commit_valid_o  (commit_valid),
    .commit_id_o     (cid)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_src(input int s, input int id, input int rd, input logic we, input logic [31:0] d);
    in_e[s] = '{CID_W'(id), REG_AW'(rd), we, d};
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) mq[k].delete();
    m_ptr = 0;
    m_rdy = '0;
    e_cv = 0; e_we = 0; e_id = '0; e_wa = '0; e_wd = '0;
  endtask

  // one cycle of the reference: scan sources from the pointer, retire one, then buffer the accepted inputs
  task automatic model_eval();
    int g;
    bit byp;
    wb_entry_t e;
    g = -1;
    byp = 0;
    for (int k = 0; k < N; k++) begin
      int i = (m_ptr + k) % N;
      if (g < 0 && (mq[i].size() > 0 || (BYP && mq[i].size() == 0 && v[i] && m_rdy[i]))) g = i;
    end
    if (g >= 0) begin
      byp = mq[g].size() == 0;
      if (byp) e = in_e[g];
      else e = mq[g].pop_front();
      e_cv = 1; e_we = e.rd_we && (e.rd_addr != 0);
      e_id = e.commit_id; e_wa = e.rd_addr; e_wd = e.rd_data;
      m_ptr = (g + 1) % N;
    end else begin
      e_cv = 0; e_we = 0;
    end
    for (int k = 0; k < N; k++)
      if (v[k] && m_rdy[k] && !(byp && g == k)) mq[k].push_back(in_e[k]);
    for (int k = 0; k < N; k++) m_rdy[k] = mq[k].size() < D;
  endtask

  task automatic step();
    model_eval();
    @(posedge clk);
    #1;
    check("commit_valid", commit_valid, e_cv);
    check("reg_we", reg_we, e_we);
    check("commit_id", cid, e_id);
    check("reg_waddr", waddr, e_wa);
    check("reg_wdata", wdata, e_wd);
    check("src_ready", src_ready, m_rdy);
  endtask

  task automatic idle();
    v = '0;
    step();
  endtask

  task automatic do_reset();
    v = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_ready", src_ready, 0);
    check("rst_commit_valid", commit_valid, 0);
    check("rst_reg_we", reg_we, 0);
    check("rst_waddr", waddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_commit_id", cid, 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    logic [CID_W-1:0] q2 [$];
    logic [CID_W-1:0] exp_id;
    bit saw_stall;
    int n2;
    bit acc2;
    for (int s = 0; s < N; s++) set_src(s, 0, 0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    do_reset();
`ifndef LONG_WB_BYPASS_EN
    tbl[0] = '{3'b000, 4'd0, 5'd0, 1'b0, 32'h0,        1'b0, 1'b0, 4'd0, 5'd0, 32'h0,        3'b111};
    tbl[1] = '{3'b001, 4'd2, 5'd5, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 4'd0, 5'd0, 32'h0,        3'b111};
    tbl[2] = '{3'b000, 4'd0, 5'd0, 1'b0, 32'h0,        1'b1, 1'b1, 4'd2, 5'd5, 32'hDEADBEEF, 3'b111};
    tbl[3] = '{3'b010, 4'd1, 5'd0, 1'b1, 32'h12345678, 1'b0, 1'b0, 4'd2, 5'd5, 32'hDEADBEEF, 3'b111};
    tbl[4] = '{3'b000, 4'd0, 5'd0, 1'b0, 32'h0,        1'b1, 1'b0, 4'd1, 5'd0, 32'h12345678, 3'b111};
    tbl[5] = '{3'b100, 4'd3, 5'd9, 1'b0, 32'hCAFE0000, 1'b0, 1'b0, 4'd1, 5'd0, 32'h12345678, 3'b111};
    tbl[6] = '{3'b000, 4'd0, 5'd0, 1'b0, 32'h0,        1'b1, 1'b0, 4'd3, 5'd9, 32'hCAFE0000, 3'b111};
    tbl[7] = '{3'b000, 4'd0, 5'd0, 1'b0, 32'h0,        1'b0, 1'b0, 4'd3, 5'd9, 32'hCAFE0000, 3'b111};
    for (int k = 0; k < 8; k++) begin
      v = tbl[k].v;
      for (int s = 0; s < N; s++) set_src(s, int'(tbl[k].id), int'(tbl[k].rd), tbl[k].we, tbl[k].data);
      step();
      check($sformatf("tbl%0d_cv", k), commit_valid, tbl[k].cv);
      check($sformatf("tbl%0d_we", k), reg_we, tbl[k].rwe);
      check($sformatf("tbl%0d_id", k), cid, tbl[k].eid);
      check($sformatf("tbl%0d_waddr", k), waddr, tbl[k].ewa);
      check($sformatf("tbl%0d_wdata", k), wdata, tbl[k].ewd);
      check($sformatf("tbl%0d_ready", k), src_ready, tbl[k].rdy);
    end
    do_reset();
    idle();
    v = 3'b111;
    for (int s = 0; s < N; s++) set_src(s, s + 1, s + 1, 1'b1, 32'(s));
    step();
    for (int s = 0; s < N; s++) set_src(s, s + 4, s + 4, 1'b1, 32'(s + 3));
    step();
    check("rr_0", {31'b0, commit_valid} << 8 | 32'(cid), 32'h100 | 32'd1);
    for (int k = 1; k < 6; k++) begin
      idle();
      check($sformatf("rr_%0d", k), {31'b0, commit_valid} << 8 | 32'(cid), 32'h100 | 32'(k + 1));
    end
    idle();
    check("rr_done", commit_valid, 0);
`else
    idle();
    v = 3'b001; set_src(0, 3, 1, 1'b1, 32'h3);
    step();
    check("byp_direct", {31'b0, commit_valid} << 8 | 32'(cid), 32'h103);
    v = 3'b100; set_src(2, 9, 2, 1'b1, 32'h9);
    step();
    check("byp_src2", {31'b0, commit_valid} << 8 | 32'(cid), 32'h109);
    v = 3'b011; set_src(0, 10, 3, 1'b1, 32'hA); set_src(1, 11, 4, 1'b1, 32'hB);
    step();
    check("byp_win", {31'b0, commit_valid} << 8 | 32'(cid), 32'h10A);
    v = 3'b001; set_src(0, 12, 5, 1'b1, 32'hC);
    step();
    check("byp_lose", {31'b0, commit_valid} << 8 | 32'(cid), 32'h10B);
    idle();
    check("byp_after", {31'b0, commit_valid} << 8 | 32'(cid), 32'h10C);
    idle();
    check("byp_done", commit_valid, 0);
`endif
    do_reset();
    idle();
    q2.delete();
    saw_stall = 0;
    n2 = 0;
    for (int c = 0; c < 30; c++) begin
      v = 3'b111;
      for (int s = 0; s < N; s++) in_e[s] = EW'({$urandom(), $urandom()});
      in_e[0].commit_id = CID_W'(c % 8);
      in_e[1].commit_id = CID_W'((c + 4) % 8);
      in_e[2].commit_id = CID_W'(8 + n2 % 8);
      acc2 = m_rdy[2];
      if (acc2) begin
        q2.push_back(in_e[2].commit_id);
        n2++;
      end
      step();
      if (!src_ready[2]) saw_stall = 1;
      if (commit_valid && cid[CID_W-1]) begin
        exp_id = q2.size() > 0 ? q2.pop_front() : '0;
        check("bp_order", cid, exp_id);
      end
    end
    for (int c = 0; c < 10; c++) begin
      idle();
      if (commit_valid && cid[CID_W-1]) begin
        exp_id = q2.size() > 0 ? q2.pop_front() : '0;
        check("bp_order", cid, exp_id);
      end
    end
    check("bp_drained", q2.size(), 0);
    check("bp_stall_seen", saw_stall, 1);
    for (int c = 0; c < 300; c++) begin
      v = N'($urandom());
      for (int s = 0; s < N; s++) in_e[s] = EW'({$urandom(), $urandom()});
      step();
    end
    v = 3'b111;
    for (int s = 0; s < N; s++) set_src(s, s + 1, s + 1, 1'b1, 32'h55 + 32'(s));
    step();
    step();
    do_reset();
    idle();
    check("post_rst_ready", src_ready, 3'b111);
    for (int c = 0; c < 3; c++) begin
      idle();
      check("post_rst_no_commit", commit_valid, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
